// File: rtl/alu_dispatch_pkg.sv
// Shared definitions for the ALU dispatch block: opcodes, flag bit positions,
// the in-flight tag record and the dispatch state encoding.
package alu_dispatch_pkg;

  localparam logic [3:0] OP_SUB   = 4'h0;
  localparam logic [3:0] OP_AND   = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_LSR   = 4'h5;
  localparam logic [3:0] OP_LSL   = 4'h6;
  localparam logic [3:0] OP_ASR   = 4'h7;
  localparam logic [3:0] OP_BREV  = 4'h8;
  localparam logic [3:0] OP_LDILO = 4'h9;
  localparam logic [3:0] OP_MPYHU = 4'hA;
  localparam logic [3:0] OP_MPYHS = 4'hB;
  localparam logic [3:0] OP_MPY   = 4'hC;
  localparam logic [3:0] OP_MOV   = 4'hD;

  // Flag vector layout is {V,N,C,Z}.
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  // One record per op issued to the ALU; killed marks a flushed op whose
  // result must still be consumed but never written back.
  typedef struct packed {
    logic [4:0] dreg;
    logic       wreg;
    logic       wflags;
    logic       is_mpy;
    logic       killed;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_MPY_WAIT = 1'b1
  } state_t;

  function automatic logic is_mpy_op(input logic [3:0] op);
    return (op == OP_MPYHU) || (op == OP_MPYHS) || (op == OP_MPY);
  endfunction

endpackage

// File: rtl/alu_dispatch_if.sv
// Bus bundle between the issue stage, the dispatcher and the ALU.
// Handshake: an op transfers on a cycle where i_valid and o_ready are both
// high; o_ready never depends on i_valid, and the issuer holds op fields
// stable while i_valid is high and o_ready low.
interface alu_dispatch_if;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [4:0]  i_dreg;
  logic        i_wreg;
  logic        i_wflags;
  logic        i_flush;
  logic        o_alu_stb;
  logic [3:0]  o_alu_op;
  logic [31:0] o_alu_a;
  logic [31:0] o_alu_b;
  logic [31:0] i_alu_c;
  logic [3:0]  i_alu_f;
  logic        i_alu_valid;
  logic        i_alu_busy;
  logic        o_wb_valid;
  logic [4:0]  o_wb_reg;
  logic [31:0] o_wb_data;
  logic        o_wb_fvalid;
  logic [3:0]  o_wb_flags;
  logic        o_illegal;
  logic [4:0]  o_illegal_reg;
  logic        o_err;
  logic [15:0] o_stall_count;

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_dreg, i_wreg, i_wflags, i_flush,
    input  i_alu_c, i_alu_f, i_alu_valid, i_alu_busy,
    output o_ready, o_alu_stb, o_alu_op, o_alu_a, o_alu_b,
    output o_wb_valid, o_wb_reg, o_wb_data, o_wb_fvalid, o_wb_flags,
    output o_illegal, o_illegal_reg, o_err, o_stall_count
  );

  modport master (
    output i_valid, i_op, i_a, i_b, i_dreg, i_wreg, i_wflags, i_flush,
    output i_alu_c, i_alu_f, i_alu_valid, i_alu_busy,
    input  o_ready, o_alu_stb, o_alu_op, o_alu_a, o_alu_b,
    input  o_wb_valid, o_wb_reg, o_wb_data, o_wb_fvalid, o_wb_flags,
    input  o_illegal, o_illegal_reg, o_err, o_stall_count
  );
endinterface

// File: rtl/alu_dispatch_tag_fifo.sv
// Two-entry FIFO of in-flight op tags. kill_all marks every stored entry as
// killed without changing occupancy. Pops of an empty FIFO are ignored.
module alu_tag_fifo
  import alu_dispatch_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  input  logic kill_all,
  output tag_t head,
  output logic full,
  output logic empty
);

  tag_t       mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; a push written after the kill keeps its own killed bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (kill_all) begin
        mem[0].killed <= 1'b1;
        mem[1].killed <= 1'b1;
      end
      if (do_push) mem[wr_ptr] <= push_tag;
      wr_ptr <= wr_ptr ^ do_push;
      rd_ptr <= rd_ptr ^ do_pop;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_dispatch.sv
// ALU dispatch: issues ops to the ALU, tracks in-flight destinations in a tag
// FIFO and turns ALU results into register/flag write-backs.
// Optional feature macro: ALU_DISPATCH_MPY_EN. When undefined, multiply
// opcodes are accepted but reported as illegal instead of being issued.
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter bit OPT_LOWPOWER = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  alu_dispatch_if.slave   bus,
  output state_t          dbg_state
);

`ifdef ALU_DISPATCH_MPY_EN
  localparam bit MPY_EN = 1'b1;
`else
  localparam bit MPY_EN = 1'b0;
`endif

  state_t      state;
  state_t      state_nxt;
  tag_t        head;
  tag_t        push_tag;
  logic        full;
  logic        empty;
  logic        is_mpy;
  logic        accept;
  logic        issue;
  logic        pop;
  logic        wb_valid;
  logic        wb_fvalid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [3:0]  wb_flags;
  logic        illegal;
  logic [4:0]  illegal_reg;
  logic        err;
  logic [15:0] stall_count;

  assign is_mpy      = is_mpy_op(bus.i_op);
  assign bus.o_ready = (state == ST_IDLE) && !bus.i_alu_busy && !bus.i_flush && !full;
  assign accept      = bus.i_valid && bus.o_ready;
  assign issue       = accept && (MPY_EN || !is_mpy);
  assign pop         = bus.i_alu_valid && !empty;

  assign bus.o_alu_stb = issue;
  assign bus.o_alu_op  = (OPT_LOWPOWER && !issue) ? 4'd0  : bus.i_op;
  assign bus.o_alu_a   = (OPT_LOWPOWER && !issue) ? 32'd0 : bus.i_a;
  assign bus.o_alu_b   = (OPT_LOWPOWER && !issue) ? 32'd0 : bus.i_b;

  assign push_tag = '{dreg: bus.i_dreg, wreg: bus.i_wreg, wflags: bus.i_wflags,
                      is_mpy: is_mpy, killed: 1'b0};

  alu_tag_fifo u_tag_fifo (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .push     (issue),
    .push_tag (push_tag),
    .pop      (pop),
    .kill_all (bus.i_flush),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Next state: wait for the multiply's own result; leave on the pop of its tag.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (issue && is_mpy) state_nxt = ST_MPY_WAIT;
      ST_MPY_WAIT: if (pop && head.is_mpy) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Write-back, illegal-op pulse, sticky error and stall counter; a flush in
  // the result cycle squashes that result as well.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wb_valid    <= 1'b0;
      wb_fvalid   <= 1'b0;
      wb_reg      <= 5'd0;
      wb_data     <= 32'd0;
      wb_flags    <= 4'd0;
      illegal     <= 1'b0;
      illegal_reg <= 5'd0;
      err         <= 1'b0;
      stall_count <= 16'd0;
    end else begin
      wb_valid  <= pop && head.wreg && !head.killed && !bus.i_flush;
      wb_fvalid <= pop && head.wflags && !head.killed && !bus.i_flush;
      if (pop) begin
        wb_reg   <= head.dreg;
        wb_data  <= bus.i_alu_c;
        wb_flags <= bus.i_alu_f;
      end
      if (bus.i_alu_valid && empty) err <= 1'b1;
      illegal <= accept && is_mpy && !MPY_EN;
      if (accept && is_mpy && !MPY_EN) illegal_reg <= bus.i_dreg;
      if (bus.i_valid && !bus.o_ready && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

  assign bus.o_wb_valid    = wb_valid;
  assign bus.o_wb_fvalid   = wb_fvalid;
  assign bus.o_wb_reg      = wb_reg;
  assign bus.o_wb_data     = wb_data;
  assign bus.o_wb_flags    = wb_flags;
  assign bus.o_illegal     = illegal;
  assign bus.o_illegal_reg = illegal_reg;
  assign bus.o_err         = err;
  assign bus.o_stall_count = stall_count;
  assign dbg_state         = state;

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 SHALL have parameter OPT_LOWPOWER, default 1; when 1, ALU operands/op are driven to zero whenever o_alu_stb is low.
REQ-002 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port i_reset_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have ports i_valid/o_ready  input/output  1/1  upstream issue handshake; transfer when both high.
REQ-005 SHALL have ports i_op/i_a/i_b  input  4/32/32  ALU opcode and operands.
REQ-006 SHALL have ports i_dreg/i_wreg/i_wflags  input  5/1/1  destination register, register-write enable, flag-write enable.
REQ-007 SHALL have port i_flush  input  1  squash write-back of all in-flight ops.
REQ-008 SHALL have ports o_alu_stb/o_alu_op/o_alu_a/o_alu_b  output  1/4/32/32  ALU request.
REQ-009 SHALL have ports i_alu_c/i_alu_f/i_alu_valid/i_alu_busy  input  32/4/1/1  ALU result, flags {V,N,C,Z}, result strobe, busy.
REQ-010 SHALL have ports o_wb_valid/o_wb_reg/o_wb_data  output  1/5/32  register write-back.
REQ-011 SHALL have ports o_wb_fvalid/o_wb_flags  output  1/4  flag write-back.
REQ-012 SHALL have ports o_illegal/o_illegal_reg  output  1/5  illegal-op pulse and its destination.
REQ-013 SHALL have ports o_err/o_stall_count  output  1/16  sticky protocol error; saturating stall counter.

Function
REQ-014 o_alu_stb SHALL equal i_valid && o_ready combinationally; o_alu_op/a/b pass i_op/i_a/i_b through.
REQ-015 o_ready SHALL be high only when state==IDLE, !i_alu_busy, !i_flush, tag FIFO not full.
REQ-016 Each issued op SHALL push tag {dreg, wreg, wflags, is_mpy, killed=0} into a 2-entry tag FIFO; each i_alu_valid SHALL pop one tag.
REQ-017 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-018 States: IDLE, MPY_WAIT. IDLE->MPY_WAIT on issue of op 4'hA-4'hC; MPY_WAIT->IDLE on i_alu_valid.
REQ-019 Non-multiply latency: issue cycle N, i_alu_valid N+1, o_wb_valid/o_wb_fvalid N+2 (registered); back-to-back issue SHALL sustain one op per cycle.
REQ-020 o_wb_valid SHALL equal popped wreg && !killed; o_wb_fvalid SHALL equal popped wflags && !killed; o_wb_data/o_wb_flags/o_wb_reg register i_alu_c/i_alu_f/tag dreg.
REQ-021 i_flush SHALL set killed on every FIFO entry, including one pushed the same cycle is impossible (o_ready low); occupancy and state unchanged, results still consumed.
REQ-022 Flush during MPY_WAIT SHALL keep MPY_WAIT until i_alu_valid, then suppress write-back.
REQ-023 i_alu_valid with empty FIFO SHALL set o_err (sticky until reset) and produce no write-back.
REQ-024 o_stall_count SHALL increment each cycle with i_valid && !o_ready, saturating at 16'hFFFF.

Reset
REQ-025 On i_reset_n low: state IDLE, FIFO empty, o_wb_valid/o_wb_fvalid/o_illegal/o_err 0, o_stall_count 0, data outputs 0.
REQ-026 Reset mid-multiply SHALL discard the tag; a later stray i_alu_valid SHALL set o_err.

Configuration
REQ-027 Macro ALU_DISPATCH_MPY_EN defined: multiplies issue to ALU per REQ-018.
REQ-028 Macro undefined: ops 4'hA-4'hC SHALL be accepted but not issued (o_alu_stb low), pulse o_illegal with o_illegal_reg=i_dreg on the next cycle, push no tag; MPY_WAIT unreachable.

Structure
REQ-029 Shared package SHALL hold opcode constants (SUB..MOV, MPYHU/MPYHS/MPY), flag-bit indices, tag struct type.
REQ-030 Tag FIFO SHALL be a sub-module alu_tag_fifo (depth 2, width 9).

Verification
REQ-031 Issue ADD a=5 b=7 dreg=3 wreg=1; ALU returns 12 at N+1 -> N+2 o_wb_valid=1, o_wb_reg=3, o_wb_data=12.
REQ-032 Four back-to-back non-mpy ops, ALU valid each next cycle -> o_ready stays 1, four write-backs in order on consecutive cycles.
REQ-033 MPY (4'hC) with ALU busy 3 cycles -> o_ready 0 for 4 cycles, o_stall_count=4 with i_valid held, single write-back.
REQ-034 Flush in cycle after issuing SUB dreg=7 wflags=1 -> ALU valid consumed, o_wb_valid=0, o_wb_fvalid=0.
REQ-035 i_alu_valid with no outstanding op -> o_err=1 persistent; reset clears.
REQ-036 Without ALU_DISPATCH_MPY_EN, issue 4'hB dreg=9 -> o_alu_stb=0, next cycle o_illegal=1, o_illegal_reg=9.
